// File: rtl/counter_if.sv
// Bus bundle for the loadable counter: parallel load request in, count and carry out.
interface counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             load;
    logic [WIDTH-1:0] out;
    logic             cout;

    modport master (
        output data,
        output load,
        input  out,
        input  cout
    );

    modport slave (
        input  data,
        input  load,
        output out,
        output cout
    );
endinterface

// File: rtl/counter.sv
// Free-running WIDTH-bit up counter with synchronous parallel load and a one-cycle
// carry pulse on wrap. Outputs come straight from flops.
module counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    counter_if.slave  bus
);
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        // Extra bit catches the wrap from all-ones to zero.
        sum    = {1'b0, out_q} + {{WIDTH{1'b0}}, 1'b1};
        out_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        if (bus.load) begin
            out_d  = bus.data;
            cout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_counter.sv
// Directed and randomized checks of the loadable counter against an arithmetic model.
module tb_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    int unsigned m_out  = 0;
    int unsigned m_cout = 0;

    counter_if #(.WIDTH(8)) bus ();

    counter #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        checks++;
        assert (bus.out === 8'(m_out)) else begin
            errors++;
            $error("FAIL %s out: got %h expected %h", tag, bus.out, 8'(m_out));
        end
        checks++;
        assert (bus.cout === 1'(m_cout)) else begin
            errors++;
            $error("FAIL %s cout: got %b expected %b", tag, bus.cout, 1'(m_cout));
        end
    endtask

    // One clock edge with the given inputs, then model update and compare.
    task automatic tick(input logic l, input logic [7:0] d, input string tag);
        bus.load = l;
        bus.data = d;
        @(posedge clk);
        #1;
        if (l) begin
            m_out  = d;
            m_cout = 0;
        end else begin
            m_cout = (m_out == 255) ? 1 : 0;
            m_out  = (m_out + 1) % 256;
        end
        check(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        m_out  = 0;
        m_cout = 0;
        check(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        bus.load = 1'b1;
        bus.data = 8'hAA;

        // Reset held with clock running overrides a pending load.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold");
        end
        #2;
        rst = 1'b0;
        tick(1'b0, 8'h00, "first_after_reset");

        for (int i = 0; i < 5; i++) tick(1'b1, 8'h00, "load_zero");
        for (int i = 0; i < 10; i++) tick(1'b0, 8'h00, "count_up");

        tick(1'b1, 8'hF0, "load_f0_a");
        tick(1'b1, 8'hF0, "load_f0_b");
        for (int i = 0; i < 15; i++) tick(1'b0, 8'h00, "count_to_ff");
        tick(1'b0, 8'h00, "wrap");
        tick(1'b0, 8'h00, "after_wrap");

        tick(1'b1, 8'hFF, "load_ff");
        tick(1'b0, 8'h00, "wrap_from_load");
        tick(1'b0, 8'h00, "after_wrap_from_load");

        // Data changing every edge while load held.
        tick(1'b1, 8'h12, "reload_a");
        tick(1'b1, 8'h34, "reload_b");
        tick(1'b0, 8'h99, "count_after_reload");

        // Async reset mid-count.
        tick(1'b1, 8'h36, "load_36");
        tick(1'b0, 8'h00, "count_37");
        async_reset_pulse("async_reset_37");
        tick(1'b0, 8'h00, "first_after_async");

        // Async reset while carry pulse is high.
        tick(1'b1, 8'hFF, "load_ff_2");
        tick(1'b0, 8'h00, "wrap_2");
        async_reset_pulse("async_reset_cout");
        tick(1'b0, 8'h00, "after_cout_reset");

        // Async reset with a wrap pending on the next edge.
        tick(1'b1, 8'hFF, "load_ff_3");
        async_reset_pulse("async_reset_pending_wrap");
        tick(1'b0, 8'h00, "after_pending_wrap_reset");

        for (int i = 0; i < 200; i++) begin
            logic       l;
            logic [7:0] d;
            l = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            if ($urandom_range(0, 15) == 0) d = 8'hFF;
            tick(l, d, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
